// File: rtl/switch_debounce_if.sv
// Bundles the raw switch pins with the debounced state and its edge strobes.
// The slave side is the debouncer; the master side drives the pins and consumes the results.
interface switch_debounce_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  modport master (
    output sw_in,
    input  sw_out,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output sw_rise,
    output sw_fall,
    output sw_changed
  );
endinterface

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for the board slide switches.
// Each output bit follows its input only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module switch_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_debounce_if.slave  sw
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;
  logic [CNT_W-1:0] cnt      [WIDTH];

  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;
  logic             changed_next;

  // Any agreement cycle discards the count; the output flips only on the edge that completes the run.
  always_comb begin
    cnt_next  = cnt;
    out_next  = out_q;
    rise_next = '0;
    fall_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == out_q[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_next[i]  = '0;
        out_next[i]  = sync2[i];
        rise_next[i] = sync2[i];
        fall_next[i] = ~sync2[i];
      end else begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
    end
    changed_next = |(rise_next | fall_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= '0;
      sync2     <= '0;
      out_q     <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      cnt       <= '{default: '0};
    end else begin
      sync1     <= sw.sw_in;
      sync2     <= sync1;
      out_q     <= out_next;
      rise_q    <= rise_next;
      fall_q    <= fall_next;
      changed_q <= changed_next;
      cnt       <= cnt_next;
    end
  end

  assign sw.sw_out     = out_q;
  assign sw.sw_rise    = rise_q;
  assign sw.sw_fall    = fall_q;
  assign sw.sw_changed = changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: a sliding-window model of "N consecutive disagreeing samples"
// is compared against the DUT every cycle, plus hand-computed checkpoints for each scenario.
module tb_switch_debounce;

  localparam int WIDTH = 16;
  localparam int DC    = 4;
  localparam int CW    = 3;

  logic clk;
  logic rst_n;

  switch_debounce_if #(.WIDTH(WIDTH)) sw_bus ();

  switch_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int rise_seen    = 0;
  int fall_seen    = 0;
  int changed_seen = 0;

  logic [WIDTH-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  logic             m_changed;
  logic [WIDTH-1:0] hist[$];

  // Model: a bit flips when the synchronised samples seen at the last DC edges all disagree with it.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (hist.size() == DC) begin
        for (int b = 0; b < WIDTH; b++) begin
          logic stable;
          stable = 1'b1;
          foreach (hist[k]) if (hist[k][b] == m_out[b]) stable = 1'b0;
          if (stable) begin
            m_out[b] = ~m_out[b];
            if (m_out[b]) m_rise[b] = 1'b1; else m_fall[b] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_bus.sw_in;
    end
    m_changed = |(m_rise | m_fall);
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs just after a falling edge, then run n cycles comparing against the model.
  task automatic applyStimulus(input logic rst_v, input logic [WIDTH-1:0] val, input int n);
    rst_n        = rst_v;
    sw_bus.sw_in = val;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("model sw_out",     sw_bus.sw_out,           m_out);
      checkOutput("model sw_rise",    sw_bus.sw_rise,          m_rise);
      checkOutput("model sw_fall",    sw_bus.sw_fall,          m_fall);
      checkOutput("model sw_changed", {15'd0, sw_bus.sw_changed}, {15'd0, m_changed});
      rise_seen    += $countones(sw_bus.sw_rise);
      fall_seen    += $countones(sw_bus.sw_fall);
      changed_seen += int'(sw_bus.sw_changed);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    sw_bus.sw_in = '0;
    @(negedge clk);

    // 1: outputs held at zero throughout reset
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 16'hA5A5, 1);
      checkOutput("reset sw_out",  sw_bus.sw_out,  16'h0000);
      checkOutput("reset sw_rise", sw_bus.sw_rise, 16'h0000);
      checkOutput("reset sw_fall", sw_bus.sw_fall, 16'h0000);
      checkOutput("reset changed", {15'd0, sw_bus.sw_changed}, 16'h0000);
    end

    // 2: single bit rise, visible after edge E0+5
    applyStimulus(1'b1, 16'h0000, 8);
    checkOutput("idle sw_out", sw_bus.sw_out, 16'h0000);
    applyStimulus(1'b1, 16'h0001, 5);
    checkOutput("t2 before E5", sw_bus.sw_out, 16'h0000);
    applyStimulus(1'b1, 16'h0001, 1);
    checkOutput("t2 sw_out",  sw_bus.sw_out,  16'h0001);
    checkOutput("t2 sw_rise", sw_bus.sw_rise, 16'h0001);
    checkOutput("t2 changed", {15'd0, sw_bus.sw_changed}, 16'h0001);
    applyStimulus(1'b1, 16'h0001, 1);
    checkOutput("t2 rise cleared", sw_bus.sw_rise, 16'h0000);
    checkOutput("t2 changed cleared", {15'd0, sw_bus.sw_changed}, 16'h0000);

    // 3: bouncing bit 3 then settling high
    rise_seen = 0;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b1, 16'h0009, 2);
      applyStimulus(1'b1, 16'h0001, 2);
    end
    checkOutput("t3 during bounce", sw_bus.sw_out, 16'h0001);
    applyStimulus(1'b1, 16'h0009, 5);
    checkOutput("t3 before 6th edge", sw_bus.sw_out, 16'h0001);
    applyStimulus(1'b1, 16'h0009, 1);
    checkOutput("t3 sw_out",  sw_bus.sw_out,  16'h0009);
    checkOutput("t3 sw_rise", sw_bus.sw_rise, 16'h0008);
    applyStimulus(1'b1, 16'h0009, 4);
    checkOutput("t3 rise pulses", 16'(rise_seen), 16'd1);

    // 4: all bits together, then partial fall
    applyStimulus(1'b1, 16'h0000, 8);
    changed_seen = 0;
    applyStimulus(1'b1, 16'hFFFF, 5);
    checkOutput("t4 before update", sw_bus.sw_out, 16'h0000);
    applyStimulus(1'b1, 16'hFFFF, 1);
    checkOutput("t4 sw_out",  sw_bus.sw_out,  16'hFFFF);
    checkOutput("t4 sw_rise", sw_bus.sw_rise, 16'hFFFF);
    checkOutput("t4 changed", {15'd0, sw_bus.sw_changed}, 16'h0001);
    applyStimulus(1'b1, 16'hFFFF, 4);
    checkOutput("t4 changed pulses", 16'(changed_seen), 16'd1);
    applyStimulus(1'b1, 16'h00F0, 5);
    applyStimulus(1'b1, 16'h00F0, 1);
    checkOutput("t4 sw_fall", sw_bus.sw_fall, 16'hFF0F);
    checkOutput("t4 sw_out2", sw_bus.sw_out,  16'h00F0);

    // 5: reset during a pending count
    applyStimulus(1'b1, 16'h0000, 8);
    changed_seen = 0;
    applyStimulus(1'b1, 16'h0080, 3);
    applyStimulus(1'b0, 16'h0080, 2);
    checkOutput("t5 in reset", sw_bus.sw_out, 16'h0000);
    applyStimulus(1'b1, 16'h0080, 5);
    checkOutput("t5 before 6th edge", sw_bus.sw_out, 16'h0000);
    checkOutput("t5 no strobes", 16'(changed_seen), 16'd0);
    applyStimulus(1'b1, 16'h0080, 1);
    checkOutput("t5 sw_out",  sw_bus.sw_out,  16'h0080);
    checkOutput("t5 sw_rise", sw_bus.sw_rise, 16'h0080);

    // 6: short pulses on bit 12 are filtered
    applyStimulus(1'b1, 16'h0080, 4);
    changed_seen = 0;
    applyStimulus(1'b1, 16'h1080, 1);
    applyStimulus(1'b1, 16'h0080, 10);
    checkOutput("t6 glitch 1", sw_bus.sw_out, 16'h0080);
    applyStimulus(1'b1, 16'h1080, 3);
    applyStimulus(1'b1, 16'h0080, 10);
    checkOutput("t6 pulse 3",    sw_bus.sw_out,    16'h0080);
    checkOutput("t6 no strobes", 16'(changed_seen), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
